nr_sqrt_seq: RTL and testbench

Iterative non-restoring integer square root for the distance path. It takes a 54-bit squared distance (dx² + dy² of 27-bit deltas) and returns the 27-bit floor root plus remainder, one result bit per clock. It sits in parallel with the alpha-max-beta-min estimator stage. It supplies the exact distance where the ~3% estimate error is unacceptable, and it uses the same 27-bit result width, so the consumer can select either source.

---
 rtl/dist_pkg.sv | 14 +
 rtl/nr_sqrt_step.sv | 25 ++
 rtl/nr_sqrt_seq.sv | 117 +++++++++++
 tb/tb_nr_sqrt_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dist_pkg.sv
// rtl/dist_pkg.sv - shared widths and state encoding for the distance path
package dist_pkg;

    localparam int W_OUT = 27;
    localparam int W_SQ  = 2 * W_OUT;
    localparam int W_R   = W_OUT + 2;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } sqrt_state_t;

endpackage

// File: rtl/nr_sqrt_step.sv
// rtl/nr_sqrt_step.sv - one combinational non-restoring square root iteration
module nr_sqrt_step #(
    parameter int W_OUT = 27
) (
    input  logic [W_OUT+1:0] r,
    input  logic [W_OUT-1:0] q,
    input  logic [1:0]       d_bits,
    output logic [W_OUT+1:0] r_next,
    output logic [W_OUT-1:0] q_next
);

    logic [W_OUT+1:0] r_shift;

    // Shifting out R's top bits is exact modulo 2^(W_OUT+2); the settled R always fits.
    always_comb begin
        r_shift = (r << 2) | {{W_OUT{1'b0}}, d_bits};
        if (!r[W_OUT+1]) begin
            r_next = r_shift - {q, 2'b01};
        end else begin
            r_next = r_shift + {q, 2'b11};
        end
        q_next = {q[W_OUT-2:0], ~r_next[W_OUT+1]};
    end

endmodule

// File: rtl/nr_sqrt_seq.sv
// rtl/nr_sqrt_seq.sv - sequential non-restoring integer square root, one root bit per clock
module nr_sqrt_seq #(
    parameter int W_OUT = dist_pkg::W_OUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*W_OUT-1:0]   square_distance,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W_OUT-1:0]     sqrt_distance,
    output logic [W_OUT:0]       sqrt_rem
);

    import dist_pkg::*;

    localparam int CNT_W = $clog2(W_OUT);

    sqrt_state_t        state;
    sqrt_state_t        state_next;
    logic [2*W_OUT-1:0] d;
    logic [W_OUT-1:0]   q;
    logic [W_OUT+1:0]   r;
    logic [CNT_W-1:0]   cnt;
    logic [W_OUT+1:0]   r_next;
    logic [W_OUT-1:0]   q_next;
    logic [W_OUT+1:0]   r_fix;

    nr_sqrt_step #(
        .W_OUT (W_OUT)
    ) u_step (
        .r      (r),
        .q      (q),
        .d_bits (d[2*W_OUT-1 -: 2]),
        .r_next (r_next),
        .q_next (q_next)
    );

    // A negative final remainder is brought back into [0, 2Q] with one add.
    assign r_fix = r_next[W_OUT+1] ? (r_next + {1'b0, q_next, 1'b1}) : r_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d             <= '0;
            q             <= '0;
            r             <= '0;
            cnt           <= '0;
            out_valid     <= 1'b0;
            sqrt_distance <= '0;
            sqrt_rem      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d   <= square_distance;
                        q   <= '0;
                        r   <= '0;
                        cnt <= CNT_W'(W_OUT - 1);
                    end
                end
                CALC: begin
                    d <= {d[2*W_OUT-3:0], 2'b00};
                    q <= q_next;
                    if (cnt == '0) begin
                        r             <= r_fix;
                        sqrt_distance <= q_next;
                        sqrt_rem      <= r_fix[W_OUT:0];
                        out_valid     <= 1'b1;
                    end else begin
                        r   <= r_next;
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nr_sqrt_seq.sv
// tb/tb_nr_sqrt_seq.sv - directed self-checking bench for nr_sqrt_seq
module tb_nr_sqrt_seq;

    localparam int W = 27;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*W-1:0] square_distance = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   sqrt_distance;
    logic [W:0]     sqrt_rem;

    int n_vec = 0;
    int n_err = 0;

    nr_sqrt_seq #(
        .W_OUT (W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .square_distance (square_distance),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .sqrt_distance   (sqrt_distance),
        .sqrt_rem        (sqrt_rem)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [2*W-1:0] v);
        @(negedge clk);
        in_valid        = 1'b1;
        square_distance = v;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || sqrt_distance !== '0 || sqrt_rem !== '0) begin
            n_err++;
            $display("FAIL reset_hold: got v=%b root=%0d rem=%0d, expected 0/0/0", out_valid, sqrt_distance, sqrt_rem);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
        end
        n_vec++;
        if (sqrt_distance !== '0 || sqrt_rem !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got root=%0d rem=%0d, expected 0/0", sqrt_distance, sqrt_rem);
        end
    endtask

    task automatic test_zero_one();
        logic [2*W-1:0] vals [2] = '{54'd0, 54'd1};
        logic [W-1:0]   roots[2] = '{27'd0, 27'd1};
        logic [W:0]     rems [2] = '{28'd0, 28'd0};
        int lat;
        for (int i = 0; i < 2; i++) begin
            issue(vals[i]);
            wait_out(lat);
            n_vec++;
            if (lat != 28) begin
                n_err++;
                $display("FAIL zero_one_latency[%0d]: got %0d cycles, expected 28", i, lat);
            end
            n_vec++;
            if (sqrt_distance !== roots[i] || sqrt_rem !== rems[i]) begin
                n_err++;
                $display("FAIL zero_one_result[%0d]: got root=%0d rem=%0d, expected root=%0d rem=%0d",
                         i, sqrt_distance, sqrt_rem, roots[i], rems[i]);
            end
            consume();
        end
    endtask

    task automatic test_squares();
        logic [2*W-1:0] vals [5] = '{54'd1000000, 54'd999999, {54{1'b1}}, 54'd2, 54'd24};
        logic [W-1:0]   roots[5] = '{27'd1000, 27'd999, 27'd134217727, 27'd1, 27'd4};
        logic [W:0]     rems [5] = '{28'd0, 28'd1998, 28'd268435454, 28'd1, 28'd8};
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue(vals[i]);
            wait_out(lat);
            n_vec++;
            if (lat != 28 || sqrt_distance !== roots[i] || sqrt_rem !== rems[i]) begin
                n_err++;
                $display("FAIL squares[%0d]: got lat=%0d root=%0d rem=%0d, expected lat=28 root=%0d rem=%0d",
                         i, lat, sqrt_distance, sqrt_rem, roots[i], rems[i]);
            end
            consume();
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL squares_release[%0d]: got out_valid=%b in_ready=%b, expected 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        issue(54'd999999);
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sqrt_distance !== 27'd999 || sqrt_rem !== 28'd1998)
                bad++;
            if (i == 3) begin
                in_valid        = 1'b1;
                square_distance = 54'd4;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL backpressure_hold: got %0d unstable cycles, expected 0", bad);
        end
        consume();
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (in_ready !== 1'b1 || out_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL backpressure_no_capture: got %0d non-idle cycles, expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int lat;
        logic [W-1:0] root_seen = '0;
        out_ready = 1'b1;
        issue(54'd144);
        do begin
            @(negedge clk);
            n++;
            if (n == 28) root_seen = sqrt_distance;
        end while (!in_ready && n < 100);
        n_vec++;
        if (n != 29 || root_seen !== 27'd12) begin
            n_err++;
            $display("FAIL back_to_back_interval: got interval=%0d root=%0d, expected 29/12", n, root_seen);
        end
        in_valid        = 1'b1;
        square_distance = 54'd1000000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(lat);
        n_vec++;
        if (lat != 28 || sqrt_distance !== 27'd1000 || sqrt_rem !== 28'd0) begin
            n_err++;
            $display("FAIL back_to_back_second: got lat=%0d root=%0d rem=%0d, expected 28/1000/0", lat, sqrt_distance, sqrt_rem);
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL back_to_back_drain: got out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        int seen = 0;
        issue(54'd999999);
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || sqrt_distance !== '0 || sqrt_rem !== '0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_calc_reset: got v=%b root=%0d rem=%0d rdy=%b, expected 0/0/0/1",
                     out_valid, sqrt_distance, sqrt_rem, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL mid_calc_dropped: got out_valid high %0d cycles, expected 0", seen);
        end
        issue(54'd144);
        wait_out(lat);
        n_vec++;
        if (lat != 28 || sqrt_distance !== 27'd12 || sqrt_rem !== 28'd0) begin
            n_err++;
            $display("FAIL mid_calc_recover: got lat=%0d root=%0d rem=%0d, expected 28/12/0", lat, sqrt_distance, sqrt_rem);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_zero_one();
        test_squares();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
